// File: rtl/hazard_stall_controller.sv
// Hazard stall controller for the 5-stage pipeline.
// Resolves the hazards that operand forwarding cannot: load-use bubbles,
// taken-branch squash and data-memory wait (with timeout into a sticky ERROR).
// Optional statistics counters are built only when HAZARD_STATS_EN is defined;
// otherwise the counter ports are tied to zero and no counter flops exist.
module hazard_stall_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,   // bubbles per load-use hazard (1..15)
  parameter int unsigned MEM_TIMEOUT       = 64,  // MEM_WAIT cycles before ERROR (2..255)
  parameter int unsigned STAT_W            = 16   // statistics counter width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        IF_ID_Rs,
  input  logic [4:0]        IF_ID_Rt,
  input  logic [1:0]        IF_ID_how_many_ops,
  input  logic              IF_ID_store_signal,
  input  logic              ID_EX_MemRead,
  input  logic [4:0]        ID_EX_RegDest,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              PC_write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EX_bubble,
  output logic              pipe_hold,
  output logic              mem_timeout,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] stall_count,
  output logic [STAT_W-1:0] flush_count,
  output logic [STAT_W-1:0] memwait_count
);

  typedef enum logic [1:0] {
    StRun       = 2'b00,
    StLoadStall = 2'b01,
    StMemWait   = 2'b10,
    StError     = 2'b11
  } state_e;

  localparam logic [7:0] LoadStallInit = 8'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] MemWaitLast   = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic rs_hit, rt_hit, load_use, mem_stall;

  // Hazard detection: a load in EX whose destination feeds the decode instruction.
  always_comb begin
    rs_hit    = (IF_ID_how_many_ops != 2'b00) && (ID_EX_RegDest == IF_ID_Rs);
    // Rt matters either as a second operand or as store data.
    rt_hit    = ((IF_ID_how_many_ops == 2'b10) || IF_ID_store_signal) &&
                (ID_EX_RegDest == IF_ID_Rt);
    load_use  = ID_EX_MemRead && (ID_EX_RegDest != 5'd0) && (rs_hit || rt_hit);
    mem_stall = mem_req && !mem_ready;
  end

  // Next-state and pipeline control outputs; priority is mem wait > branch > load-use.
  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_hold    = 1'b0;
    mem_timeout  = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;

    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (mem_stall) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
            state_d     = StMemWait;
            cnt_d       = 8'd1;
          end else if (branch_taken) begin
            // Any concurrent load-use is moot: the dependent instruction is squashed.
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (load_use) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = StLoadStall;
              cnt_d   = LoadStallInit;
            end
          end
        end

        StLoadStall: begin
          if (mem_stall) begin
            // Remaining bubbles are dropped; load-use is re-evaluated back in RUN.
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
            state_d     = StMemWait;
            cnt_d       = 8'd1;
          end else begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            if (cnt_q <= 8'd1) begin
              state_d = StRun;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end

        StMemWait: begin
          if (mem_ready) begin
            // Release cycle: the whole pipeline advances with default controls.
            state_d = StRun;
            cnt_d   = 8'd0;
          end else begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
            if (cnt_q >= MemWaitLast) begin
              state_d = StError;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end

        StError: begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          pipe_hold   = 1'b1;
          mem_timeout = 1'b1;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] StatMax = '1;

  logic [STAT_W-1:0] stall_q, flush_q, memwait_q;

  // Saturating event counters driven by the control outputs of the current cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      if (ID_EX_bubble && !IF_ID_flush && (stall_q != StatMax)) begin
        stall_q <= stall_q + STAT_W'(1);
      end
      if (IF_ID_flush && (flush_q != StatMax)) begin
        flush_q <= flush_q + STAT_W'(1);
      end
      if (pipe_hold && (memwait_q != StatMax)) begin
        memwait_q <= memwait_q + STAT_W'(1);
      end
    end
  end

  assign stall_count   = stall_q;
  assign flush_count   = flush_q;
  assign memwait_count = memwait_q;
`else
  assign stall_count   = '0;
  assign flush_count   = '0;
  assign memwait_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Two instances share stimulus:
// dut a (LOAD_STALL_CYCLES=1, MEM_TIMEOUT=64, STAT_W=16) and
// dut b (LOAD_STALL_CYCLES=3, MEM_TIMEOUT=4,  STAT_W=2).
// Control outputs are packed as {PC_write, IF_ID_write, IF_ID_flush,
// ID_EX_bubble, pipe_hold, mem_timeout, state[1:0]}.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, rd;
  logic [1:0] ops;
  logic       store, memread, br, mreq, mrdy;

  logic        pcw_a, ifw_a, fl_a, bub_a, hold_a, tmo_a;
  logic [1:0]  st_a;
  logic [15:0] sc_a, fc_a, mc_a;
  logic        pcw_b, ifw_b, fl_b, bub_b, hold_b, tmo_b;
  logic [1:0]  st_b;
  logic [1:0]  sc_b, fc_b, mc_b;

  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {pcw_a, ifw_a, fl_a, bub_a, hold_a, tmo_a, st_a};
  assign ctl_b = {pcw_b, ifw_b, fl_b, bub_b, hold_b, tmo_b, st_b};

  localparam logic [7:0] Def0 = 8'hC0, Def2 = 8'hC2, Def3 = 8'hC3;
  localparam logic [7:0] Stl0 = 8'h10, Stl1 = 8'h11, Flu0 = 8'hF0;
  localparam logic [7:0] Frz0 = 8'h08, Frz1 = 8'h09, Frz2 = 8'h0A, Err = 8'h0F;

  int checks = 0;
  int errors = 0;
  // Expected statistics, derived from the expected control vectors.
  int e_sc_a = 0, e_fc_a = 0, e_mc_a = 0;
  int e_sc_b = 0, e_fc_b = 0, e_mc_b = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(64), .STAT_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_how_many_ops(ops),
    .IF_ID_store_signal(store), .ID_EX_MemRead(memread), .ID_EX_RegDest(rd),
    .branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
    .PC_write(pcw_a), .IF_ID_write(ifw_a), .IF_ID_flush(fl_a), .ID_EX_bubble(bub_a),
    .pipe_hold(hold_a), .mem_timeout(tmo_a), .state(st_a),
    .stall_count(sc_a), .flush_count(fc_a), .memwait_count(mc_a)
  );

  hazard_stall_controller #(
    .LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4), .STAT_W(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_how_many_ops(ops),
    .IF_ID_store_signal(store), .ID_EX_MemRead(memread), .ID_EX_RegDest(rd),
    .branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
    .PC_write(pcw_b), .IF_ID_write(ifw_b), .IF_ID_flush(fl_b), .ID_EX_bubble(bub_b),
    .pipe_hold(hold_b), .mem_timeout(tmo_b), .state(st_b),
    .stall_count(sc_b), .flush_count(fc_b), .memwait_count(mc_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int max_v);
    return (v < max_v) ? v + 1 : v;
  endfunction

  task automatic drive(input logic [4:0] i_rs, input logic [4:0] i_rt, input logic [1:0] i_ops,
                       input logic i_st, input logic i_mr, input logic [4:0] i_rd,
                       input logic i_br, input logic i_mq, input logic i_my);
    rs = i_rs; rt = i_rt; ops = i_ops; store = i_st; memread = i_mr; rd = i_rd;
    br = i_br; mreq = i_mq; mrdy = i_my;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One cycle: settle, compare, advance the statistics model, pass a rising edge.
  task automatic step(input string tag, input logic r, input logic [7:0] ea,
                      input logic [7:0] eb);
    rst = r;
    #1;
    check_eq({tag, ".a"}, 32'(ctl_a), 32'(ea));
    check_eq({tag, ".b"}, 32'(ctl_b), 32'(eb));
    check_eq({tag, ".a.stall"},   32'(sc_a), e_sc_a);
    check_eq({tag, ".a.flush"},   32'(fc_a), e_fc_a);
    check_eq({tag, ".a.memwait"}, 32'(mc_a), e_mc_a);
    check_eq({tag, ".b.stall"},   32'(sc_b), e_sc_b);
    check_eq({tag, ".b.flush"},   32'(fc_b), e_fc_b);
    check_eq({tag, ".b.memwait"}, 32'(mc_b), e_mc_b);
`ifdef HAZARD_STATS_EN
    if (r) begin
      e_sc_a = 0; e_fc_a = 0; e_mc_a = 0;
      e_sc_b = 0; e_fc_b = 0; e_mc_b = 0;
    end else begin
      if (ea[4] && !ea[5]) e_sc_a = sat_inc(e_sc_a, 65535);
      if (ea[5])           e_fc_a = sat_inc(e_fc_a, 65535);
      if (ea[3])           e_mc_a = sat_inc(e_mc_a, 65535);
      if (eb[4] && !eb[5]) e_sc_b = sat_inc(e_sc_b, 3);
      if (eb[5])           e_fc_b = sat_inc(e_fc_b, 3);
      if (eb[3])           e_mc_b = sat_inc(e_mc_b, 3);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);

    step("reset",      1'b1, Def0, Def0);
    step("idle",       1'b0, Def0, Def0);
    // Load-use on Rs; b stalls three cycles with states 00,01,01,00.
    drive(5'd5, 5'd0, 2'b01, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_rs",      1'b0, Stl0, Stl0);
    idle();
    step("lu_tail1",   1'b0, Def0, Stl1);
    step("lu_tail2",   1'b0, Def0, Stl1);
    step("lu_done",    1'b0, Def0, Def0);
    // Destination r0 never stalls.
    drive(5'd0, 5'd0, 2'b01, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lu_r0",      1'b0, Def0, Def0);
    // Rt ignored with one operand, honoured with two.
    drive(5'd0, 5'd7, 2'b01, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    step("rt_ops01",   1'b0, Def0, Def0);
    drive(5'd0, 5'd7, 2'b10, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    step("rt_ops10",   1'b0, Stl0, Stl0);
    // Memory wait preempts b's load stall; leftover bubbles are dropped.
    drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("ls_preempt", 1'b0, Frz0, Frz1);
    drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step("mw_release", 1'b0, Def2, Def2);
    idle();
    step("post_rel",   1'b0, Def0, Def0);
    // Store data register counts even with no operands.
    drive(5'd0, 5'd7, 2'b00, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    step("store_rt",   1'b0, Stl0, Stl0);
    idle();
    step("st_tail1",   1'b0, Def0, Stl1);
    step("st_tail2",   1'b0, Def0, Stl1);
    step("st_done",    1'b0, Def0, Def0);
    // Branch beats load-use; no LOAD_STALL entry.
    drive(5'd5, 5'd0, 2'b01, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step("br_lu",      1'b0, Flu0, Flu0);
    idle();
    step("br_after",   1'b0, Def0, Def0);
    // Memory wait beats branch and load-use; branch is re-presented on release.
    drive(5'd5, 5'd0, 2'b01, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    step("mw_br_lu",   1'b0, Frz0, Frz0);
    step("mw_ign_br",  1'b0, Frz2, Frz2);
    drive(5'd5, 5'd0, 2'b01, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    step("mw_rdy_br",  1'b0, Def2, Def2);
    drive(5'd5, 5'd0, 2'b01, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step("br_replay",  1'b0, Flu0, Flu0);
    // Five not-ready cycles: a waits them out, b times out after four.
    drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("mw1",        1'b0, Frz0, Frz0);
    step("mw2",        1'b0, Frz2, Frz2);
    step("mw3",        1'b0, Frz2, Frz2);
    step("mw4",        1'b0, Frz2, Frz2);
    step("mw5",        1'b0, Frz2, Err);
    drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step("mw_ready",   1'b0, Def2, Err);
    idle();
    step("err_sticky", 1'b0, Def0, Err);
    // Same-cycle request and ready never stalls.
    drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step("req_rdy",    1'b0, Def0, Err);
    idle();
    step("rst_err",    1'b1, Def0, Def3);
    step("after_rst",  1'b0, Def0, Def0);
    // Reset out of MEM_WAIT.
    drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("mw_enter",   1'b0, Frz0, Frz0);
    step("rst_mw",     1'b1, Def2, Def2);
    idle();
    step("final",      1'b0, Def0, Def0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
